alu_cmd_controller: RTL

Sequential command front-end for the N-bit ALU. It accepts operation requests over a valid/ready channel and drives a combinational ALU instance through registered operand and control ports. It captures the ALU result and flags, keeps an architectural NZCV flag register, and returns the result over a valid/ready response channel. It sits between a datapath or instruction sequencer and the ALU.

---
 rtl/alu_cmd_pkg.sv | 39 +++
 rtl/alu_cmd_controller_if.sv | 25 ++
 rtl/alu_cmd_controller_divider.sv | 52 +++++
 rtl/alu_cmd_controller.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command controller: op codes, FSM states, flag bit positions.
// ALU_CMD_DIV_EN adds the DIV state used by the built-in restoring divider.
package alu_cmd_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LSR  = 4'd5;
  localparam logic [3:0] OP_LSL  = 4'd6;
  localparam logic [3:0] OP_MOD  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_LAST = OP_DIV;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
`ifdef ALU_CMD_DIV_EN
    , ST_DIV = 2'd3
`endif
  } state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_MOD) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_controller_if.sv
// Command/response valid-ready channel between a requester and alu_cmd_controller.
interface alu_cmd_controller_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [3:0]   cmd_op;
  logic         cmd_setflags;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_setflags, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_setflags, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_cmd_controller_divider.sv
// Sequential restoring divider: one quotient bit per cycle, done pulses N cycles after start.
// Divide by zero falls out naturally as quotient all-ones, remainder = dividend.
module seq_restoring_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  dsr;
  logic [CW-1:0] cnt;
  logic [N:0]    trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign trial = {remainder, quotient[N-1]} - {1'b0, dsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= '0;
        quotient  <= dividend;
        dsr       <= divisor;
        cnt       <= CW'(N);
        busy      <= 1'b1;
      end else if (busy) begin
        remainder <= trial[N] ? {remainder[N-2:0], quotient[N-1]} : trial[N-1:0];
        quotient  <= {quotient[N-2:0], ~trial[N]};
        cnt       <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_cmd_controller.sv
// Valid/ready command front-end driving a combinational ALU through registered ports.
// ALU_CMD_DIV_EN routes ops 7/9 to an internal restoring divider instead of the ALU.
//
// state   | meaning
// IDLE    | ready for a command, ALU ports hold last operands
// EXEC    | ALU evaluating registered operands, result captured at cycle end
// DIV     | internal divider iterating (ALU_CMD_DIV_EN only)
// RESP    | response presented until rsp_ready
module alu_cmd_controller
  import alu_cmd_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_controller_if.slave  bus,
  output logic [3:0]           flags_nzcv,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic [3:0]           alu_control,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_v,
  input  logic                 alu_c,
  input  logic                 alu_n,
  input  logic                 alu_z
);
  state_t state;
  logic   setflags_q;
  logic   cmd_fire;

  assign cmd_fire = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;

`ifdef ALU_CMD_DIV_EN
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [N-1:0] div_quo;
  logic [N-1:0] div_rem;
  logic [N-1:0] div_res;

  assign div_start = cmd_fire && is_div_op(bus.cmd_op);
  assign div_res   = (alu_control == OP_DIV) ? div_quo : div_rem;

  seq_restoring_divider #(.N(N)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (bus.cmd_a),
    .divisor   (bus.cmd_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bus.cmd_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
      flags_nzcv     <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_control    <= '0;
      setflags_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (cmd_fire) begin
            bus.cmd_ready <= 1'b0;
            alu_a         <= bus.cmd_a;
            alu_b         <= bus.cmd_b;
            alu_control   <= bus.cmd_op;
            setflags_q    <= bus.cmd_setflags;
            if (!is_legal_op(bus.cmd_op)) begin
              bus.rsp_result <= '0;
              bus.rsp_err    <= 1'b1;
              bus.rsp_valid  <= 1'b1;
              state          <= ST_RESP;
            end
`ifdef ALU_CMD_DIV_EN
            else if (is_div_op(bus.cmd_op)) begin
              state <= ST_DIV;
            end
`endif
            else begin
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          bus.rsp_result <= alu_result;
          bus.rsp_err    <= is_div_op(alu_control) && (alu_b == '0);
          bus.rsp_valid  <= 1'b1;
          if (setflags_q) begin
            flags_nzcv[FLG_N] <= alu_n;
            flags_nzcv[FLG_Z] <= alu_z;
            flags_nzcv[FLG_C] <= alu_c;
            flags_nzcv[FLG_V] <= alu_v;
          end
          state <= ST_RESP;
        end

`ifdef ALU_CMD_DIV_EN
        ST_DIV: begin
          if (div_done && !div_busy) begin
            bus.rsp_result <= div_res;
            bus.rsp_err    <= (alu_b == '0);
            bus.rsp_valid  <= 1'b1;
            // Divider flags are produced locally; carry and overflow are meaningless here.
            if (setflags_q) begin
              flags_nzcv[FLG_N] <= div_res[N-1];
              flags_nzcv[FLG_Z] <= (div_res == '0);
              flags_nzcv[FLG_C] <= 1'b0;
              flags_nzcv[FLG_V] <= 1'b0;
            end
            state <= ST_RESP;
          end
        end
`endif

        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: begin
          bus.cmd_ready <= 1'b0;
          bus.rsp_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
